// File: rtl/pcie_tlp_pkg.sv
// +--------------------------------------------------------------------------+
// | pcie_tlp_pkg : TLP type codes, RX FSM states, header word map, credits   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package pcie_tlp_pkg;

  localparam logic [4:0] TYPE_MWR = 5'b00000;
  localparam logic [4:0] TYPE_MRD = 5'b00000;
  localparam logic [4:0] TYPE_MSG = 5'b10000;
  localparam logic [4:0] TYPE_CPL = 5'b01010;

  localparam logic [3:0] W_FMT   = 4'd0;
  localparam logic [3:0] W_LEN   = 4'd1;
  localparam logic [3:0] W_BE    = 4'd3;
  localparam logic [3:0] W_ADDR3 = 4'd5;
  localparam logic [3:0] W_ADDR4 = 4'd7;
  localparam logic [3:0] W_DATA3 = 4'd6;
  localparam logic [3:0] W_DATA4 = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_DATA   = 3'd2,
    ST_DROP   = 3'd3,
    ST_RETIRE = 3'd4
  } rx_state_e;

  function automatic logic tlp_is_mwr(input logic [1:0] fmt, input logic [4:0] typ);
    return fmt[1] && (typ == TYPE_MWR);
  endfunction

  function automatic logic tlp_is_msg(input logic [4:0] typ);
    return typ[4:3] == TYPE_MSG[4:3];
  endfunction

  function automatic logic tlp_is_cpl(input logic [4:0] typ);
    return typ[4:1] == TYPE_CPL[4:1];
  endfunction

  // Length 0 encodes 1024 DW; 256 credits wraps to 8'h00.
  function automatic logic [7:0] dw_credits(input logic [9:0] len);
    logic [10:0] n;
    n = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    n = n + 11'd3;
    return n[9:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pcie_tlp_hdr_cap.sv
// +--------------------------------------------------------------------------+
// | pcie_tlp_hdr_cap : TLP word counter and header/first-data field capture  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pcie_tlp_hdr_cap
  import pcie_tlp_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] rx_data_i,
  input  logic        rx_st_i,
  input  logic        rx_malf_i,
  output logic [1:0]  fmt_o,
  output logic [4:0]  typ_o,
  output logic [9:0]  len_o,
  output logic [3:0]  be_o,
  output logic [9:0]  addr_o,
  output logic [7:0]  byte0_o,
  output logic        dvld_o,
  output logic        malf_o,
  output logic        data_word_o
);

  logic [3:0] idx_q, idx_d;
  logic [1:0] fmt_q, fmt_d;
  logic [4:0] typ_q, typ_d;
  logic [9:0] len_q, len_d;
  logic [3:0] be_q, be_d;
  logic [9:0] addr_q, addr_d;
  logic [7:0] byte0_q, byte0_d;
  logic       dvld_q, dvld_d;
  logic       malf_q, malf_d;
  logic [3:0] addr_idx, data_idx;

  assign addr_idx    = fmt_q[0] ? W_ADDR4 : W_ADDR3;
  assign data_idx    = fmt_q[0] ? W_DATA4 : W_DATA3;
  assign data_word_o = !rx_st_i && fmt_q[1] && (idx_q == data_idx);

  always_comb begin
    idx_d   = (idx_q == 4'hF) ? idx_q : idx_q + 4'd1;
    fmt_d   = fmt_q;
    typ_d   = typ_q;
    len_d   = len_q;
    be_d    = be_q;
    addr_d  = addr_q;
    byte0_d = byte0_q;
    dvld_d  = dvld_q;
    malf_d  = malf_q | rx_malf_i;
    if (rx_st_i) begin
      idx_d  = W_FMT + 4'd1;
      fmt_d  = rx_data_i[14:13];
      typ_d  = rx_data_i[12:8];
      dvld_d = 1'b0;
      malf_d = rx_malf_i;
    end else begin
      if (idx_q == W_LEN)    len_d  = rx_data_i[9:0];
      if (idx_q == W_BE)     be_d   = rx_data_i[3:0];
      if (idx_q == addr_idx) addr_d = rx_data_i[11:2];
      if (data_word_o && !dvld_q) begin
        byte0_d = rx_data_i[15:8];
        dvld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q   <= '0;
      fmt_q   <= '0;
      typ_q   <= '0;
      len_q   <= '0;
      be_q    <= '0;
      addr_q  <= '0;
      byte0_q <= '0;
      dvld_q  <= 1'b0;
      malf_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      fmt_q   <= fmt_d;
      typ_q   <= typ_d;
      len_q   <= len_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      byte0_q <= byte0_d;
      dvld_q  <= dvld_d;
      malf_q  <= malf_d;
    end
  end

  // Next-state values so the retire decision can include the rx_end word.
  assign fmt_o   = fmt_d;
  assign typ_o   = typ_d;
  assign len_o   = len_d;
  assign be_o    = be_d;
  assign addr_o  = addr_d;
  assign byte0_o = byte0_d;
  assign dvld_o  = dvld_d;
  assign malf_o  = malf_d;

endmodule

`default_nettype wire

// File: rtl/pcie_rx_led_sink.sv
// +--------------------------------------------------------------------------+
// | pcie_rx_led_sink : VC0 RX TLP sink, LED register write, credit return    |
// | Rev 1.0   Optional stats counters: PCIE_RX_LED_STATS_EN                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pcie_rx_led_sink
  import pcie_tlp_pkg::*;
#(
  parameter int unsigned BAR_SEL    = 0,
  parameter logic [11:0] LED_OFFSET = 12'h000,
  parameter logic [7:0]  LED_RST    = 8'hFE
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] rx_data,
  input  logic        rx_st,
  input  logic        rx_end,
  input  logic        rx_malf_tlp,
  input  logic [6:0]  rx_bar_hit,
  output logic        ph_processed,
  output logic        pd_processed,
  output logic [7:0]  pd_num,
  output logic        nph_processed,
  output logic        npd_processed,
  output logic [7:0]  npd_num,
  output logic        ur_np_ext,
  output logic        ur_p_ext,
  output logic        led_load,
`ifdef PCIE_RX_LED_STATS_EN
  output logic [7:0]  led_val,
  output logic [15:0] wr_cnt,
  output logic [15:0] drop_cnt
`else
  output logic [7:0]  led_val
`endif
);

  localparam logic [6:0] BAR_MASK = 7'(1) << BAR_SEL;

  rx_state_e  state_q;
  logic [1:0] fmt;
  logic [4:0] typ;
  logic [9:0] len;
  logic [3:0] be;
  logic [9:0] addr;
  logic [7:0] byte0;
  logic       dvld, malf, data_word;
  logic       retire_ok, is_mwr, is_posted, has_data, led_hit;
  logic       ph_q, pd_q, nph_q, npd_q, ur_np_q, ur_p_q, led_load_q;
  logic [7:0] pd_num_q, npd_num_q, led_val_q;

  pcie_tlp_hdr_cap u_hdr_cap (
    .clk         (clk),
    .rstn        (rstn),
    .rx_data_i   (rx_data),
    .rx_st_i     (rx_st),
    .rx_malf_i   (rx_malf_tlp),
    .fmt_o       (fmt),
    .typ_o       (typ),
    .len_o       (len),
    .be_o        (be),
    .addr_o      (addr),
    .byte0_o     (byte0),
    .dvld_o      (dvld),
    .malf_o      (malf),
    .data_word_o (data_word)
  );

  // A TLP whose rx_end coincides with rx_st, or arrives with no TLP open, is dropped silently.
  assign retire_ok = !rx_st && (state_q inside {ST_HDR, ST_DATA, ST_DROP});
  assign is_mwr    = tlp_is_mwr(fmt, typ);
  assign is_posted = is_mwr || tlp_is_msg(typ);
  assign has_data  = fmt[1];
  assign led_hit   = retire_ok && is_mwr && dvld && !malf && be[3] &&
                     (|(rx_bar_hit & BAR_MASK)) && (addr == LED_OFFSET[11:2]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      ph_q       <= 1'b0;
      pd_q       <= 1'b0;
      nph_q      <= 1'b0;
      npd_q      <= 1'b0;
      ur_np_q    <= 1'b0;
      ur_p_q     <= 1'b0;
      led_load_q <= 1'b0;
      pd_num_q   <= 8'h00;
      npd_num_q  <= 8'h00;
      led_val_q  <= LED_RST;
    end else begin
      ph_q       <= 1'b0;
      pd_q       <= 1'b0;
      nph_q      <= 1'b0;
      npd_q      <= 1'b0;
      ur_np_q    <= 1'b0;
      ur_p_q     <= 1'b0;
      led_load_q <= 1'b0;
      if (rx_end) begin
        state_q <= ST_RETIRE;
        if (led_hit) begin
          led_load_q <= 1'b1;
          led_val_q  <= byte0;
        end
        if (retire_ok && is_posted) begin
          ph_q   <= 1'b1;
          ur_p_q <= !is_mwr;
          if (has_data) begin
            pd_q     <= 1'b1;
            pd_num_q <= dw_credits(len);
          end
        end else if (retire_ok && !tlp_is_cpl(typ)) begin
          nph_q   <= 1'b1;
          ur_np_q <= 1'b1;
          if (has_data) begin
            npd_q     <= 1'b1;
            npd_num_q <= dw_credits(len);
          end
        end
      end else if (rx_st) begin
        state_q <= ST_HDR;
      end else begin
        case (state_q)
          ST_HDR: begin
            if (!is_mwr)        state_q <= ST_DROP;
            else if (data_word) state_q <= ST_DATA;
          end
          ST_RETIRE: state_q <= ST_IDLE;
          default:   state_q <= state_q;
        endcase
      end
    end
  end

`ifdef PCIE_RX_LED_STATS_EN
  logic [15:0] wr_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt_q   <= 16'h0000;
      drop_cnt_q <= 16'h0000;
    end else if (rx_end) begin
      if (led_hit) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign wr_cnt   = wr_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

  assign ph_processed  = ph_q;
  assign pd_processed  = pd_q;
  assign pd_num        = pd_num_q;
  assign nph_processed = nph_q;
  assign npd_processed = npd_q;
  assign npd_num       = npd_num_q;
  assign ur_np_ext     = ur_np_q;
  assign ur_p_ext      = ur_p_q;
  assign led_load      = led_load_q;
  assign led_val       = led_val_q;

endmodule

`default_nettype wire

// File: tb/tb_pcie_rx_led_sink.sv
// +--------------------------------------------------------------------------+
// | tb_pcie_rx_led_sink : directed TLP vectors with hand-computed results    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pcie_rx_led_sink;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_st = 1'b0;
  logic        rx_end = 1'b0;
  logic        rx_malf_tlp = 1'b0;
  logic [6:0]  rx_bar_hit = '0;
  logic        ph_processed, pd_processed, nph_processed, npd_processed;
  logic        ur_np_ext, ur_p_ext, led_load;
  logic [7:0]  pd_num, npd_num, led_val;
`ifdef PCIE_RX_LED_STATS_EN
  logic [15:0] wr_cnt, drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] tlp [0:15];

  always #5 clk = ~clk;

  pcie_rx_led_sink dut (
    .clk           (clk),
    .rstn          (rstn),
    .rx_data       (rx_data),
    .rx_st         (rx_st),
    .rx_end        (rx_end),
    .rx_malf_tlp   (rx_malf_tlp),
    .rx_bar_hit    (rx_bar_hit),
    .ph_processed  (ph_processed),
    .pd_processed  (pd_processed),
    .pd_num        (pd_num),
    .nph_processed (nph_processed),
    .npd_processed (npd_processed),
    .npd_num       (npd_num),
    .ur_np_ext     (ur_np_ext),
    .ur_p_ext      (ur_p_ext),
    .led_load      (led_load),
`ifdef PCIE_RX_LED_STATS_EN
    .led_val       (led_val),
    .wr_cnt        (wr_cnt),
    .drop_cnt      (drop_cnt)
`else
    .led_val       (led_val)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Pulse vector order: {ph, pd, nph, npd, ur_np, ur_p, led_load}
  task automatic check_out(input string tag, input logic [6:0] pulses,
                           input logic [7:0] pdn, input logic [7:0] npdn, input logic [7:0] led);
    check({tag, ".pulses"}, {25'd0, ph_processed, pd_processed, nph_processed, npd_processed,
                             ur_np_ext, ur_p_ext, led_load}, {25'd0, pulses});
    if (pulses[5]) check({tag, ".pd_num"}, {24'd0, pd_num}, {24'd0, pdn});
    if (pulses[3]) check({tag, ".npd_num"}, {24'd0, npd_num}, {24'd0, npdn});
    check({tag, ".led_val"}, {24'd0, led_val}, {24'd0, led});
  endtask

  // 3DW header + two data words; data upper byte is byte0.
  task automatic mk3(input logic [15:0] w0, input logic [9:0] len, input logic [3:0] be,
                     input logic [15:0] addr, input logic [7:0] d0);
    tlp[0] = w0;            tlp[1] = {6'd0, len}; tlp[2] = 16'h0000; tlp[3] = {12'h000, be};
    tlp[4] = 16'h0000;      tlp[5] = addr;        tlp[6] = {d0, 8'h5A}; tlp[7] = 16'h0000;
  endtask

  task automatic mk4(input logic [15:0] w0, input logic [9:0] len, input logic [3:0] be,
                     input logic [15:0] addr, input logic [7:0] d0);
    tlp[0] = w0;       tlp[1] = {6'd0, len}; tlp[2] = 16'h0000; tlp[3] = {12'h000, be};
    tlp[4] = 16'h0000; tlp[5] = 16'h0000;    tlp[6] = 16'h0000; tlp[7] = addr;
    tlp[8] = {d0, 8'h00}; tlp[9] = 16'h0000;
  endtask

  task automatic send(input int n, input int malf_at, input logic [6:0] bar);
    for (int i = 0; i < n; i++) begin
      rx_data     = tlp[i];
      rx_st       = (i == 0);
      rx_end      = (i == n - 1);
      rx_malf_tlp = (i == malf_at);
      rx_bar_hit  = bar;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    rx_data = '0; rx_st = 1'b0; rx_end = 1'b0; rx_malf_tlp = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 7'b0000000, 8'h00, 8'h00, 8'hFE);
    check("reset.pd_num", {24'd0, pd_num}, 32'd0);
    check("reset.npd_num", {24'd0, npd_num}, 32'd0);
    rstn = 1'b1;
    idle();

    mk4(16'h6000, 10'd0, 4'hF, 16'h0004, 8'h81);
    send(10, -1, 7'b0000001);
    check_out("mwr4_len1024", 7'b1100000, 8'h00, 8'h00, 8'hFE);
    idle();

    mk3(16'h4000, 10'd1, 4'hF, 16'h0000, 8'hA5);
    send(8, -1, 7'b0000001);
    check_out("mwr3_led", 7'b1100001, 8'h01, 8'h00, 8'hA5);
    idle();
    check_out("mwr3_after", 7'b0000000, 8'h00, 8'h00, 8'hA5);

    mk3(16'h0000, 10'd1, 4'hF, 16'h0000, 8'h00);
    send(6, -1, 7'b0000001);
    check_out("mrd3", 7'b0010100, 8'h00, 8'h00, 8'hA5);
    idle();

    mk3(16'h4000, 10'd1, 4'hF, 16'h0000, 8'h77);
    send(8, 1, 7'b0000001);
    check_out("mwr_malf", 7'b1100000, 8'h01, 8'h00, 8'hA5);
    idle();

    mk3(16'h4000, 10'd1, 4'hF, 16'h0000, 8'h11);
    send(8, -1, 7'b0000001);
    check_out("b2b_first", 7'b1100001, 8'h01, 8'h00, 8'h11);
    mk3(16'h4000, 10'd1, 4'hF, 16'h0000, 8'h22);
    rx_data = tlp[0]; rx_st = 1'b1; rx_end = 1'b0;
    @(posedge clk); #1;
    check_out("b2b_gap", 7'b0000000, 8'h00, 8'h00, 8'h11);
    for (int i = 1; i < 8; i++) begin
      rx_data = tlp[i]; rx_st = 1'b0; rx_end = (i == 7);
      @(posedge clk); #1;
    end
    check_out("b2b_second", 7'b1100001, 8'h01, 8'h00, 8'h22);
    idle();

    mk3(16'h4400, 10'd1, 4'hF, 16'h0000, 8'h00);
    send(8, -1, 7'b0000001);
    check_out("cfgwr", 7'b0011100, 8'h00, 8'h01, 8'h22);
    idle();

    mk4(16'h3000, 10'd0, 4'h0, 16'h0000, 8'h00);
    send(8, -1, 7'b0000001);
    check_out("msg", 7'b1000010, 8'h00, 8'h00, 8'h22);
    idle();

    mk3(16'h4A00, 10'd1, 4'hF, 16'h0000, 8'h44);
    send(8, -1, 7'b0000001);
    check_out("cpld", 7'b0000000, 8'h00, 8'h00, 8'h22);
    idle();

    mk3(16'h4000, 10'd5, 4'h7, 16'h0000, 8'h55);
    send(8, -1, 7'b0000001);
    check_out("mwr_be7_len5", 7'b1100000, 8'h02, 8'h00, 8'h22);
    idle();

    mk3(16'h4000, 10'd1, 4'hF, 16'h0000, 8'h66);
    send(8, -1, 7'b0000010);
    check_out("mwr_bar_miss", 7'b1100000, 8'h01, 8'h00, 8'h22);
    idle();

    mk3(16'h4000, 10'd1, 4'hF, 16'h0000, 8'h99);
    for (int i = 0; i < 7; i++) begin
      rx_data = tlp[i]; rx_st = (i == 0); rx_end = 1'b0; rx_bar_hit = 7'b0000001;
      @(posedge clk); #1;
    end
    #2 rstn = 1'b0;
    #1;
    check_out("rst_mid", 7'b0000000, 8'h00, 8'h00, 8'hFE);
    @(posedge clk); #1;
    rstn = 1'b1;
    rx_data = tlp[7]; rx_end = 1'b1;
    @(posedge clk); #1;
    check_out("rst_tail", 7'b0000000, 8'h00, 8'h00, 8'hFE);
    idle();

    mk3(16'h4000, 10'd1, 4'hF, 16'h0000, 8'h3C);
    send(8, -1, 7'b0000001);
    check_out("after_rst", 7'b1100001, 8'h01, 8'h00, 8'h3C);
    idle();
`ifdef PCIE_RX_LED_STATS_EN
    check("wr_cnt", {16'd0, wr_cnt}, 32'd1);
    check("drop_cnt", {16'd0, drop_cnt}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
